calc_input_ctrl: RTL and testbench

CALC_INPUT_CTRL -- requirements
Module: calc_input_ctrl

---
 rtl/calc_pkg.sv | 25 ++
 rtl/btn_debouncer.sv | 93 +++++++++
 rtl/calc_input_ctrl.sv | 111 +++++++++++
 tb/tb_calc_input_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
//------------------------------------------------------------------------------
// Module   : calc_pkg
// Brief    : Shared debounce state encoding and button index constants for
//            the calculator input controller.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package calc_pkg;

  typedef enum logic [1:0] {
    LOW       = 2'd0,
    WAIT_HIGH = 2'd1,
    HIGH      = 2'd2,
    WAIT_LOW  = 2'd3
  } db_state_t;

  localparam int BTN_ENTER  = 0;
  localparam int BTN_UNDO   = 1;
  localparam int BTN_FORMAT = 2;
  localparam int N_BTN      = 3;

endpackage

`default_nettype wire

// File: rtl/btn_debouncer.sv
//------------------------------------------------------------------------------
// Module   : btn_debouncer
// Brief    : 2-flop synchronizer, 4-state debounce FSM with stability counter
//            and a one-cycle press pulse (no pulse on release).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module btn_debouncer
  import calc_pkg::*;
#(
  parameter int N_DEBOUNCER = 10
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      i_btn_raw,
  output logic      o_pulse,
  output db_state_t o_state
);

  localparam logic [N_DEBOUNCER-1:0] C_CNT_MAX = '1;
  localparam logic [N_DEBOUNCER-1:0] C_CNT_ONE = N_DEBOUNCER'(1);

  logic                   r_sync_meta;
  logic                   r_sync;
  db_state_t              r_state;
  db_state_t              w_state_next;
  logic [N_DEBOUNCER-1:0] r_cnt;
  logic [N_DEBOUNCER-1:0] w_cnt_inc;
  logic                   w_done;
  logic                   w_press;
  logic                   r_pulse;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync_meta <= 1'b0;
      r_sync      <= 1'b0;
    end else begin
      r_sync_meta <= i_btn_raw;
      r_sync      <= r_sync_meta;
    end
  end

  assign w_cnt_inc = r_cnt + C_CNT_ONE;
  // Reaching the max on this edge completes 2**N_DEBOUNCER stable samples.
  assign w_done    = (w_cnt_inc == C_CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= LOW;
      r_cnt   <= '0;
      r_pulse <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_pulse <= w_press;
      if (w_state_next != r_state) begin
        r_cnt <= '0;
      end else if (r_cnt != C_CNT_MAX) begin
        r_cnt <= w_cnt_inc;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      LOW: begin
        if (r_sync) w_state_next = WAIT_HIGH;
      end
      WAIT_HIGH: begin
        if (!r_sync)     w_state_next = LOW;
        else if (w_done) w_state_next = HIGH;
      end
      HIGH: begin
        if (!r_sync) w_state_next = WAIT_LOW;
      end
      WAIT_LOW: begin
        if (r_sync)      w_state_next = HIGH;
        else if (w_done) w_state_next = LOW;
      end
      default: w_state_next = LOW;
    endcase
  end

  always_comb begin
    w_press = (r_state == WAIT_HIGH) && r_sync && w_done;
    o_pulse = r_pulse;
    o_state = r_state;
  end

endmodule

`default_nettype wire

// File: rtl/calc_input_ctrl.sv
//------------------------------------------------------------------------------
// Module   : calc_input_ctrl
// Brief    : Debounced Enter/Undo/Format pulses and Enter-gated switch
//            snapshot. Optional Undo auto-repeat via UNDO_AUTOREPEAT_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module calc_input_ctrl
  import calc_pkg::*;
#(
  parameter int N_DEBOUNCER   = 10,
  parameter int REPEAT_DELAY  = 50_000_000,
  parameter int REPEAT_PERIOD = 20_000_000
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        BtnEnter,
  input  logic        BtnUndo,
  input  logic        BtnFormat,
  input  logic [15:0] SwRaw,
  output logic        Enter,
  output logic        Undo,
  output logic        DisplayFormat,
  output logic [15:0] DataIn,
  output logic [2:0]  BtnHeld
);

  logic [N_BTN-1:0] w_btn_raw;
  logic [N_BTN-1:0] w_pulse;
  db_state_t        w_state [N_BTN];
  logic             w_rep_pulse;
  logic [15:0]      r_sw_meta;
  logic [15:0]      r_sw_sync;
  logic [15:0]      r_data_hold;

  assign w_btn_raw = {BtnFormat, BtnUndo, BtnEnter};

  for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
    btn_debouncer #(
      .N_DEBOUNCER (N_DEBOUNCER)
    ) u_debouncer (
      .clk       (clk),
      .rst_n     (resetN),
      .i_btn_raw (w_btn_raw[gi]),
      .o_pulse   (w_pulse[gi]),
      .o_state   (w_state[gi])
    );
    assign BtnHeld[gi] = (w_state[gi] == HIGH) || (w_state[gi] == WAIT_LOW);
  end

`ifdef UNDO_AUTOREPEAT_EN
  localparam int C_REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int C_REP_W   = $clog2(C_REP_MAX + 1);
  localparam logic [C_REP_W-1:0] C_REP_DELAY  = C_REP_W'(REPEAT_DELAY);
  localparam logic [C_REP_W-1:0] C_REP_PERIOD = C_REP_W'(REPEAT_PERIOD);
  localparam logic [C_REP_W-1:0] C_REP_ONE    = C_REP_W'(1);

  logic [C_REP_W-1:0] r_rep_cnt;
  logic [C_REP_W-1:0] r_rep_target;
  logic [C_REP_W-1:0] w_rep_next;
  logic               r_rep_pulse;

  assign w_rep_next = r_rep_cnt + C_REP_ONE;

  // First repeat after REPEAT_DELAY held cycles, then every REPEAT_PERIOD.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_rep_cnt    <= '0;
      r_rep_target <= C_REP_DELAY;
      r_rep_pulse  <= 1'b0;
    end else if (w_state[BTN_UNDO] != HIGH) begin
      r_rep_cnt    <= '0;
      r_rep_target <= C_REP_DELAY;
      r_rep_pulse  <= 1'b0;
    end else if (w_rep_next == r_rep_target) begin
      r_rep_cnt    <= '0;
      r_rep_target <= C_REP_PERIOD;
      r_rep_pulse  <= 1'b1;
    end else begin
      r_rep_cnt    <= w_rep_next;
      r_rep_pulse  <= 1'b0;
    end
  end

  assign w_rep_pulse = r_rep_pulse;
`else
  assign w_rep_pulse = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_sw_meta   <= 16'h0000;
      r_sw_sync   <= 16'h0000;
      r_data_hold <= 16'h0000;
    end else begin
      r_sw_meta <= SwRaw;
      r_sw_sync <= r_sw_meta;
      if (w_pulse[BTN_ENTER]) r_data_hold <= r_sw_sync;
    end
  end

  // Enter wins a same-cycle collision; the Undo event is discarded.
  assign Enter         = w_pulse[BTN_ENTER];
  assign Undo          = (w_pulse[BTN_UNDO] | w_rep_pulse) & ~w_pulse[BTN_ENTER];
  assign DisplayFormat = w_pulse[BTN_FORMAT];
  assign DataIn        = w_pulse[BTN_ENTER] ? r_sw_sync : r_data_hold;

endmodule

`default_nettype wire

// File: tb/tb_calc_input_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_calc_input_ctrl
// Brief    : Self-checking bench for calc_input_ctrl with a run-length
//            behavioural model and directed scenarios.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_calc_input_ctrl;

  localparam int ND     = 4;
  localparam int DB_LEN = 1 << ND;
  localparam int RD     = 40;
  localparam int RP     = 10;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        BtnEnter = 1'b0;
  logic        BtnUndo = 1'b0;
  logic        BtnFormat = 1'b0;
  logic [15:0] SwRaw = 16'h0000;
  logic        Enter;
  logic        Undo;
  logic        DisplayFormat;
  logic [15:0] DataIn;
  logic [2:0]  BtnHeld;

  calc_input_ctrl #(
    .N_DEBOUNCER   (ND),
    .REPEAT_DELAY  (RD),
    .REPEAT_PERIOD (RP)
  ) dut (
    .clk           (clk),
    .resetN        (resetN),
    .BtnEnter      (BtnEnter),
    .BtnUndo       (BtnUndo),
    .BtnFormat     (BtnFormat),
    .SwRaw         (SwRaw),
    .Enter         (Enter),
    .Undo          (Undo),
    .DisplayFormat (DisplayFormat),
    .DataIn        (DataIn),
    .BtnHeld       (BtnHeld)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int          enter_q[$];
  int          undo_q[$];
  int          fmt_q[$];
  logic [15:0] data_q[$];

  // Model: each debounced level flips after DB_LEN consecutive synchronized
  // samples that disagree with it; a flip to 1 is a press pulse.
  bit          ms1[3];
  bit          ms2[3];
  bit          mlvl[3];
  bit          mpulse[3];
  int          mrun[3];
  bit          mrep;
  logic [15:0] msw1, msw2, mdata;
`ifdef UNDO_AUTOREPEAT_EN
  int          mage;
`endif

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 3; b++) begin
      ms1[b] = 0; ms2[b] = 0; mlvl[b] = 0; mpulse[b] = 0; mrun[b] = 0;
    end
    mrep = 0; msw1 = '0; msw2 = '0; mdata = '0;
`ifdef UNDO_AUTOREPEAT_EN
    mage = 0;
`endif
  endtask

  task automatic model_step();
    bit raw[3];
    bit in_high;
    raw[0] = BtnEnter; raw[1] = BtnUndo; raw[2] = BtnFormat;
    in_high = mlvl[1] && (mrun[1] == 0);
    for (int b = 0; b < 3; b++) begin
      mpulse[b] = 0;
      if (ms2[b] != mlvl[b]) begin
        mrun[b]++;
        if (mrun[b] == DB_LEN) begin
          mlvl[b]   = !mlvl[b];
          mrun[b]   = 0;
          mpulse[b] = mlvl[b];
        end
      end else begin
        mrun[b] = 0;
      end
      ms2[b] = ms1[b];
      ms1[b] = raw[b];
    end
    mrep = 0;
`ifdef UNDO_AUTOREPEAT_EN
    if (in_high) begin
      mage++;
      if (mage >= RD && ((mage - RD) % RP) == 0) mrep = 1;
    end else begin
      mage = 0;
    end
`else
    if (in_high && mrep) mrep = 0;
`endif
    msw2 = msw1;
    msw1 = SwRaw;
    if (mpulse[0]) mdata = msw2;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      cyc++;
      if (!resetN) model_reset();
      else         model_step();
    end
  end

  // Per-cycle comparison and pulse logging.
  initial begin
    logic [21:0] act, exp;
    forever begin
      @(negedge clk);
      act = {Enter, Undo, DisplayFormat, BtnHeld, DataIn};
      if (!resetN) exp = '0;
      else exp = {mpulse[0], (mpulse[1] | mrep) & !mpulse[0], mpulse[2],
                  mlvl[2], mlvl[1], mlvl[0], mdata};
      cmp("outputs_vs_model", 32'(act), 32'(exp));
      if (Enter === 1'b1) begin enter_q.push_back(cyc); data_q.push_back(DataIn); end
      if (Undo === 1'b1) undo_q.push_back(cyc);
      if (DisplayFormat === 1'b1) fmt_q.push_back(cyc);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_logs();
    enter_q.delete(); undo_q.delete(); fmt_q.delete(); data_q.delete();
  endtask

  initial begin
    int c0, last, cr;
    tick(3);
    cmp("reset_outputs", 32'({Enter, Undo, DisplayFormat, BtnHeld, DataIn}), 32'h0);
    resetN = 1'b1;
    tick(5);

    // Clean Enter press with a switch snapshot.
    clear_logs();
    SwRaw = 16'hBEEF; BtnEnter = 1'b1; c0 = cyc;
    tick(25);
    cmp("enter_count", 32'(enter_q.size()), 32'd1);
    if (enter_q.size() > 0) begin
      cmp("enter_latency", 32'(enter_q[0] - c0), 32'd18);
      cmp("datain_at_enter", 32'(data_q[0]), 32'hBEEF);
    end
    SwRaw = 16'h1234; BtnEnter = 1'b0;
    tick(25);
    cmp("datain_hold", 32'(DataIn), 32'hBEEF);
    cmp("enter_release_no_pulse", 32'(enter_q.size()), 32'd1);

    // Bouncing Undo, then stable high.
    clear_logs();
    BtnUndo = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick(3);
      BtnUndo = ~BtnUndo;
    end
    last = cyc;
    tick(25);
    cmp("undo_bounce_count", 32'(undo_q.size()), 32'd1);
    if (undo_q.size() > 0) cmp("undo_bounce_latency", 32'(undo_q[0] - last), 32'd18);
    BtnUndo = 1'b0;
    tick(25);

    // Enter and Undo together: Enter wins.
    clear_logs();
    BtnEnter = 1'b1; BtnUndo = 1'b1; c0 = cyc;
    tick(20);
    cmp("held_enter_undo", 32'(BtnHeld), 32'h3);
    tick(5);
    cmp("collide_enter_count", 32'(enter_q.size()), 32'd1);
    if (enter_q.size() > 0) cmp("collide_enter_latency", 32'(enter_q[0] - c0), 32'd18);
    BtnEnter = 1'b0; BtnUndo = 1'b0;
    tick(25);
    cmp("collide_undo_count", 32'(undo_q.size()), 32'd0);

    // Reset in the middle of a Format debounce, button held through release.
    clear_logs();
    BtnFormat = 1'b1;
    tick(10);
    resetN = 1'b0;
    #1;
    cmp("async_reset_outputs", 32'({Enter, Undo, DisplayFormat, BtnHeld, DataIn}), 32'h0);
    tick(3);
    resetN = 1'b1; cr = cyc;
    tick(25);
    cmp("fmt_after_reset_count", 32'(fmt_q.size()), 32'd1);
    if (fmt_q.size() > 0) cmp("fmt_after_reset_latency", 32'(fmt_q[0] - cr), 32'd18);
    BtnFormat = 1'b0;
    tick(25);

    // Enter and Format together are independent.
    clear_logs();
    BtnEnter = 1'b1; BtnFormat = 1'b1;
    tick(22);
    cmp("indep_enter_count", 32'(enter_q.size()), 32'd1);
    cmp("indep_fmt_count", 32'(fmt_q.size()), 32'd1);
    if (enter_q.size() > 0 && fmt_q.size() > 0)
      cmp("indep_same_cycle", 32'(fmt_q[0] - enter_q[0]), 32'd0);
    BtnEnter = 1'b0; BtnFormat = 1'b0;
    tick(25);

    // Long Undo hold: 100 cycles beyond the first pulse.
    clear_logs();
    BtnUndo = 1'b1; c0 = cyc;
    tick(118);
    BtnUndo = 1'b0;
    tick(40);
`ifdef UNDO_AUTOREPEAT_EN
    cmp("repeat_count", 32'(undo_q.size()), 32'd8);
    if (undo_q.size() == 8) begin
      cmp("repeat_first_latency", 32'(undo_q[0] - c0), 32'd18);
      for (int i = 1; i < 8; i++)
        cmp("repeat_offset", 32'(undo_q[i] - undo_q[0]), 32'(30 + 10 * i));
    end
`else
    cmp("hold_single_undo", 32'(undo_q.size()), 32'd1);
    if (undo_q.size() > 0) cmp("hold_undo_latency", 32'(undo_q[0] - c0), 32'd18);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
